rv32v_lane_agu: RTL and testbench
=================================

Name: rv32v_lane_agu

Overview:
- Parametrised multi-lane vector address-generation unit; successor to the fixed two-lane address chain inside the RV32V execute stage.
- Accepts one vector load/store descriptor: base, stride, vl, mode, element width.
- Sequences it over several cycles, emitting NUM_LANES element addresses per beat with per-lane valid and mask.
- Sits between decode/execute and the memory stage, under hazard-unit stall and flush control.

Parameters:
NUM_LANES, 2, lanes (elements) issued per beat; power of two, 1..8
VL_W, 7, width of vl / element pointer (max vl = 2^VL_W - 1)
ADDR_W, 32, address width

Ports:
CLK  in  1  clock
nRST  in  1  asynchronous active-low reset
flush  in  1  abort current sequence (hazard unit)
stall  in  1  freeze all state (hazard unit)
start_valid  in  1  descriptor valid
start_ready  out  1  unit can accept descriptor
mode  in  2  agu_mode_t: UNIT, STRIDED, INDEXED
eew  in  2  eew_t: E8, E16, E32 (1/2/4 bytes)
base  in  ADDR_W  base address (xs1)
stride  in  ADDR_W  signed byte stride (STRIDED only)
vl  in  VL_W  element count
idx  in  NUM_LANES*ADDR_W  per-lane byte offsets for current beat (INDEXED), zero-extended
mask  in  NUM_LANES  per-lane mask for current beat
out_valid  out  1  beat valid
out_ready  in  1  memory stage accepts beat
out_addr  out  NUM_LANES*ADDR_W  lane addresses
out_lane_en  out  NUM_LANES  lane k active: (elem_ptr+k < vl) & mask[k]
out_elem_idx  out  VL_W  element index of lane 0
done  out  1  one-cycle pulse, sequence complete

Behaviour:
- Reset: state IDLE; start_ready=1, out_valid=0, done=0, out_addr=0, out_lane_en=0, out_elem_idx=0, all internal registers 0.
- States: IDLE, ISSUE, FIN.
- IDLE: start_ready=1. On start_valid & !stall, latch descriptor, acc<=base, elem_ptr<=0; go to ISSUE, or FIN if vl==0.
- ISSUE: out_valid=1; out_addr/out_lane_en derived combinationally from acc, elem_ptr, latched step, and live idx/mask.
  - UNIT: step = eew bytes; addr_k = acc + k*step.
  - STRIDED: step = stride; addr_k = acc + k*step.
  - INDEXED: addr_k = base + idx_k.
  - All arithmetic modulo 2^ADDR_W (wraps silently; negative stride is two's complement).
- Beat accepted when out_valid & out_ready & !stall: elem_ptr += NUM_LANES; acc += NUM_LANES*step.
  - If elem_ptr+NUM_LANES >= vl: done=1 in that same cycle, next state IDLE.
- FIN (vl==0 only): done=1 for one cycle, no beat issued; then IDLE.
- Stall: no state, counter or accumulator update; outputs hold stable; done is suppressed and re-asserted when the stall releases.
- Flush: highest priority after reset. Next state IDLE, done not pulsed, out_valid=0 next cycle. start_valid in the same cycle is ignored.
- Back-to-back: start_ready=0 outside IDLE. A new descriptor is accepted earliest the cycle after done.
- Masked lanes (mask[k]=0) still carry a computed address; only out_lane_en drops. Tail lanes beyond vl have out_lane_en=0.
- Latency: first beat valid the cycle after start acceptance; a sequence takes ceil(vl/NUM_LANES) beats.

Optional Feature:
- RV32V_AGU_MISALIGN_CHECK_EN defined: adds output misalign_err (1) and misalign_lane (NUM_LANES).
  - On an accepted beat where any enabled lane address is not aligned to eew, misalign_err pulses one cycle and misalign_lane flags the offending lanes.
  - The sequence aborts to IDLE without done.
- Undefined: ports absent; no alignment check.

Decomposition:
- rv32v_types_pkg gains agu_mode_t {UNIT, STRIDED, INDEXED}, eew_t {E8, E16, E32}, agu_state_t {IDLE, ISSUE, FIN}, and function eew_bytes(eew_t).
- One sub-module: rv32v_agu_lane_addr, purely combinational per-lane address select/add (mode, acc, step, k, base, idx). Instantiated NUM_LANES times via generate.

Test Plan:
- NUM_LANES=2, UNIT, E32, base=0x1000, vl=5, mask=11, out_ready=1 -> beats (0x1000,0x1004 en=11), (0x1008,0x100C en=11), (0x1010,0x1014 en=01); done with 3rd beat.
- STRIDED, stride=-8, base=0x10, vl=4 -> (0x10,0x08), (0x00,0xFFFFFFF8); done on 2nd beat.
- INDEXED, base=0x100, idx=(0x20,0x4), mask=10 -> out_addr (0x120,0x104), out_lane_en=10.
- vl=0 accepted -> out_valid never asserts; done pulses exactly once, the cycle after accept; start_ready back to 1 after.
- Mid-sequence out_ready=0 for 3 cycles, then stall=1 for 2 cycles -> out_addr/out_elem_idx stable throughout; flush on beat 2 -> IDLE next cycle, no done, start_ready=1.
- With RV32V_AGU_MISALIGN_CHECK_EN: UNIT E32 base=0x1002 -> misalign_err=1, misalign_lane=11 on first beat, return to IDLE, no done.

Source files
------------

// File: rtl/rv32v_types_pkg.sv
// rtl/rv32v_types_pkg.sv - shared enums and helpers for the RV32V lane AGU
package rv32v_types_pkg;

  typedef enum logic [1:0] {
    UNIT    = 2'd0,
    STRIDED = 2'd1,
    INDEXED = 2'd2
  } agu_mode_t;

  typedef enum logic [1:0] {
    E8  = 2'd0,
    E16 = 2'd1,
    E32 = 2'd2
  } eew_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    FIN   = 2'd2
  } agu_state_t;

  function automatic logic [2:0] eew_bytes(eew_t e);
    case (e)
      E16:     eew_bytes = 3'd2;
      E32:     eew_bytes = 3'd4;
      default: eew_bytes = 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/rv32v_agu_lane_addr.sv
// rtl/rv32v_agu_lane_addr.sv - combinational address of one lane within a beat
module rv32v_agu_lane_addr
  import rv32v_types_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LANE   = 0
) (
  input  agu_mode_t          i_mode,
  input  logic [ADDR_W-1:0]  i_acc,
  input  logic [ADDR_W-1:0]  i_step,
  input  logic [ADDR_W-1:0]  i_base,
  input  logic [ADDR_W-1:0]  i_idx,
  output logic [ADDR_W-1:0]  o_addr
);

  always_comb begin
    o_addr = i_acc + ADDR_W'(LANE) * i_step;
    if (i_mode == INDEXED) begin
      o_addr = i_base + i_idx;
    end
  end

endmodule

// File: rtl/rv32v_lane_agu.sv
// rtl/rv32v_lane_agu.sv - multi-lane vector AGU sequencer
// Optional RV32V_AGU_MISALIGN_CHECK_EN adds misalign_err/misalign_lane and aborts on misaligned beats.
module rv32v_lane_agu
  import rv32v_types_pkg::*;
#(
  parameter int NUM_LANES = 2,
  parameter int VL_W      = 7,
  parameter int ADDR_W    = 32
) (
  input  logic                          CLK,
  input  logic                          nRST,
  input  logic                          flush,
  input  logic                          stall,
  input  logic                          start_valid,
  output logic                          start_ready,
  input  logic [1:0]                    mode,
  input  logic [1:0]                    eew,
  input  logic [ADDR_W-1:0]             base,
  input  logic [ADDR_W-1:0]             stride,
  input  logic [VL_W-1:0]               vl,
  input  logic [NUM_LANES*ADDR_W-1:0]   idx,
  input  logic [NUM_LANES-1:0]          mask,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NUM_LANES*ADDR_W-1:0]   out_addr,
  output logic [NUM_LANES-1:0]          out_lane_en,
  output logic [VL_W-1:0]               out_elem_idx,
  output logic                          done
`ifdef RV32V_AGU_MISALIGN_CHECK_EN
  ,
  output logic                          misalign_err,
  output logic [NUM_LANES-1:0]          misalign_lane
`endif
);

  localparam int PW = VL_W + 1;

  agu_state_t                  r_state, w_next_state;
  agu_mode_t                   r_mode;
  logic [ADDR_W-1:0]           r_base, r_step, r_acc;
  logic [VL_W-1:0]             r_vl, r_elem_ptr;
  logic                        w_issue, w_start, w_fire, w_last, w_misalign;
  logic [NUM_LANES*ADDR_W-1:0] w_lane_addr;
  logic [NUM_LANES-1:0]        w_lane_en;

  assign w_issue = (r_state == ISSUE);
  assign w_start = (r_state == IDLE) && start_valid && !stall && !flush;
  assign w_fire  = w_issue && out_ready && !stall && !flush;
  // Pointer math is one bit wider so the final beat near max vl cannot wrap.
  assign w_last  = ({1'b0, r_elem_ptr} + PW'(NUM_LANES)) >= {1'b0, r_vl};

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    rv32v_agu_lane_addr #(
      .ADDR_W (ADDR_W),
      .LANE   (k)
    ) u_lane_addr (
      .i_mode (r_mode),
      .i_acc  (r_acc),
      .i_step (r_step),
      .i_base (r_base),
      .i_idx  (idx[k*ADDR_W +: ADDR_W]),
      .o_addr (w_lane_addr[k*ADDR_W +: ADDR_W])
    );
    assign w_lane_en[k] = (({1'b0, r_elem_ptr} + PW'(k)) < {1'b0, r_vl}) && mask[k];
  end

  assign start_ready  = (r_state == IDLE);
  assign out_valid    = w_issue;
  assign out_addr     = w_issue ? w_lane_addr : '0;
  assign out_lane_en  = w_issue ? w_lane_en : '0;
  assign out_elem_idx = r_elem_ptr;

`ifdef RV32V_AGU_MISALIGN_CHECK_EN
  eew_t                 r_eew;
  logic [NUM_LANES-1:0] w_bad;

  always_comb begin
    w_bad = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      case (r_eew)
        E16:     w_bad[k] = w_lane_en[k] && w_lane_addr[k*ADDR_W];
        E32:     w_bad[k] = w_lane_en[k] && (|w_lane_addr[k*ADDR_W +: 2]);
        default: w_bad[k] = 1'b0;
      endcase
    end
  end

  assign w_misalign    = |w_bad;
  assign misalign_err  = w_fire && w_misalign;
  assign misalign_lane = w_fire ? w_bad : '0;
`else
  assign w_misalign = 1'b0;
`endif

  always_comb begin
    w_next_state = r_state;
    done         = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          w_next_state = (vl == '0) ? FIN : ISSUE;
        end
      end
      ISSUE: begin
        if (w_fire) begin
          if (w_misalign) begin
            w_next_state = IDLE;
          end else if (w_last) begin
            done         = 1'b1;
            w_next_state = IDLE;
          end
        end
      end
      FIN: begin
        if (!stall && !flush) begin
          done         = 1'b1;
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
    if (flush) begin
      w_next_state = IDLE;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state    <= IDLE;
      r_mode     <= UNIT;
      r_base     <= '0;
      r_step     <= '0;
      r_acc      <= '0;
      r_vl       <= '0;
      r_elem_ptr <= '0;
`ifdef RV32V_AGU_MISALIGN_CHECK_EN
      r_eew      <= E8;
`endif
    end else begin
      r_state <= w_next_state;
      if (w_start) begin
        r_mode     <= agu_mode_t'(mode);
        r_base     <= base;
        r_step     <= (agu_mode_t'(mode) == STRIDED) ? stride : ADDR_W'(eew_bytes(eew_t'(eew)));
        r_acc      <= base;
        r_vl       <= vl;
        r_elem_ptr <= '0;
`ifdef RV32V_AGU_MISALIGN_CHECK_EN
        r_eew      <= eew_t'(eew);
`endif
      end
      if (w_fire) begin
        r_elem_ptr <= r_elem_ptr + VL_W'(NUM_LANES);
        r_acc      <= r_acc + ADDR_W'(NUM_LANES) * r_step;
      end
    end
  end

endmodule

// File: tb/tb_rv32v_lane_agu.sv
// tb/tb_rv32v_lane_agu.sv - self-checking bench for rv32v_lane_agu
module tb_rv32v_lane_agu;

  localparam int N  = 2;
  localparam int VW = 7;
  localparam int AW = 32;

  logic          CLK = 1'b0;
  logic          nRST = 1'b0;
  logic          flush = 1'b0, stall = 1'b0, start_valid = 1'b0, out_ready = 1'b0;
  logic [1:0]    mode = '0, eew = '0;
  logic [AW-1:0] base = '0, stride = '0;
  logic [VW-1:0] vl = '0;
  logic [N*AW-1:0] idx = '0;
  logic [N-1:0]  mask = '0;
  logic          start_ready, out_valid, done;
  logic [N*AW-1:0] out_addr;
  logic [N-1:0]  out_lane_en;
  logic [VW-1:0] out_elem_idx;
`ifdef RV32V_AGU_MISALIGN_CHECK_EN
  logic          misalign_err;
  logic [N-1:0]  misalign_lane;
`endif

  rv32v_lane_agu #(.NUM_LANES(N), .VL_W(VW), .ADDR_W(AW)) dut (
    .CLK(CLK), .nRST(nRST), .flush(flush), .stall(stall),
    .start_valid(start_valid), .start_ready(start_ready),
    .mode(mode), .eew(eew), .base(base), .stride(stride), .vl(vl),
    .idx(idx), .mask(mask), .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_lane_en(out_lane_en), .out_elem_idx(out_elem_idx),
    .done(done)
`ifdef RV32V_AGU_MISALIGN_CHECK_EN
    , .misalign_err(misalign_err), .misalign_lane(misalign_lane)
`endif
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  int n_done   = 0;
  int n_valid  = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  // Reference model: sequence phase plus element index; addresses from base + element*step.
  int            m_phase = 0;
  int            m_elem  = 0;
  int            m_vl    = 0;
  int            m_mode  = 0;
  logic [AW-1:0] m_base  = '0;
  logic [AW-1:0] m_step  = '0;

  function automatic logic [AW-1:0] bytes_of(input logic [1:0] e);
    return (e == 2'd2) ? 32'd4 : (e == 2'd1) ? 32'd2 : 32'd1;
  endfunction

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      m_phase = 0;
      m_elem  = 0;
    end else if (flush) begin
      m_phase = 0;
    end else begin
      case (m_phase)
        0: if (start_valid && !stall) begin
          m_mode  = int'(mode);
          m_base  = base;
          m_step  = (mode == 2'd1) ? stride : bytes_of(eew);
          m_vl    = int'(vl);
          m_elem  = 0;
          m_phase = (vl == 0) ? 2 : 1;
        end
        1: if (out_ready && !stall) begin
          if (m_elem + N >= m_vl) m_phase = 0;
          m_elem += N;
        end
        default: if (!stall) m_phase = 0;
      endcase
    end
  end

  logic [N*AW-1:0] exp_addr;
  logic [N-1:0]    exp_en;
  logic            exp_done;

  always @(negedge CLK) begin
    if (nRST && chk_en) begin
      for (int k = 0; k < N; k++) begin
        logic [AW-1:0] ek;
        ek = AW'(m_elem + k);
        exp_addr[k*AW +: AW] = (m_mode == 2) ? m_base + idx[k*AW +: AW] : m_base + ek * m_step;
        exp_en[k] = (m_elem + k < m_vl) && mask[k];
      end
      exp_done = !flush && !stall &&
                 ((m_phase == 1 && out_ready && (m_elem + N >= m_vl)) || m_phase == 2);
      chk("start_ready", 64'(start_ready), 64'(m_phase == 0));
      chk("out_valid", 64'(out_valid), 64'(m_phase == 1));
      chk("done", 64'(done), 64'(exp_done));
      if (m_phase == 1) begin
        chk("out_addr", 64'(out_addr), 64'(exp_addr));
        chk("out_lane_en", 64'(out_lane_en), 64'(exp_en));
        chk("out_elem_idx", 64'(out_elem_idx), 64'(m_elem));
      end
    end
  end

  typedef struct packed {
    logic [N*AW-1:0] addr;
    logic [N-1:0]    en;
    logic            dn;
  } beat_t;
  beat_t beats[$];

  always @(negedge CLK) begin
    if (nRST) begin
      if (done) n_done++;
      if (out_valid) n_valid++;
      if (out_valid && out_ready && !stall && !flush)
        beats.push_back('{addr: out_addr, en: out_lane_en, dn: done});
    end
  end

  task automatic start_desc(input logic [1:0] m, input logic [1:0] e, input logic [AW-1:0] b,
                            input logic [AW-1:0] s, input logic [VW-1:0] v);
    mode = m; eew = e; base = b; stride = s; vl = v;
    start_valid = 1'b1;
    cyc();
    start_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (!start_ready && n < 300) begin
      cyc();
      n++;
    end
    if (!start_ready) chk({name, "_timeout"}, 64'(start_ready), 64'd1);
  endtask

  task automatic chk_beat(input string name, input int i, input logic [63:0] a,
                          input logic [1:0] en, input logic dn);
    if (i < beats.size()) begin
      chk({name, "_addr"}, 64'(beats[i].addr), a);
      chk({name, "_en"}, 64'(beats[i].en), 64'(en));
      chk({name, "_done"}, 64'(beats[i].dn), 64'(dn));
    end else begin
      chk({name, "_missing"}, 64'(beats.size()), 64'(i + 1));
    end
  endtask

  logic [N*AW-1:0] a0;
  logic [VW-1:0]   e0;
  int              d0, v0;

  initial begin
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_start_ready", 64'(start_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_out_addr", 64'(out_addr), 64'd0);
    chk("rst_lane_en", 64'(out_lane_en), 64'd0);
    chk("rst_elem_idx", 64'(out_elem_idx), 64'd0);
    #2 nRST = 1'b1;
    cyc();
    chk_en = 1'b1;

    mask = 2'b11; out_ready = 1'b1;
    beats.delete(); d0 = n_done;
    start_desc(2'd0, 2'd2, 32'h1000, 32'h0, 7'd5);
    wait_idle("unit");
    chk("unit_nbeats", 64'(beats.size()), 64'd3);
    chk_beat("unit_b0", 0, 64'h00001004_00001000, 2'b11, 1'b0);
    chk_beat("unit_b1", 1, 64'h0000100C_00001008, 2'b11, 1'b0);
    chk_beat("unit_b2", 2, 64'h00001014_00001010, 2'b01, 1'b1);
    chk("unit_ndone", 64'(n_done - d0), 64'd1);

    beats.delete();
    start_desc(2'd1, 2'd0, 32'h10, 32'hFFFF_FFF8, 7'd4);
    wait_idle("strided");
    chk("str_nbeats", 64'(beats.size()), 64'd2);
    chk_beat("str_b0", 0, 64'h00000008_00000010, 2'b11, 1'b0);
    chk_beat("str_b1", 1, 64'hFFFFFFF8_00000000, 2'b11, 1'b1);

    beats.delete();
    idx = {32'h4, 32'h20}; mask = 2'b10;
    start_desc(2'd2, 2'd0, 32'h100, 32'h0, 7'd2);
    wait_idle("indexed");
    chk_beat("idx_b0", 0, 64'h00000104_00000120, 2'b10, 1'b1);
    mask = 2'b11;

    d0 = n_done; v0 = n_valid;
    start_desc(2'd0, 2'd0, 32'h40, 32'h0, 7'd0);
    @(negedge CLK);
    chk("vl0_done_pulse", 64'(done), 64'd1);
    cyc();
    @(negedge CLK);
    chk("vl0_ready_back", 64'(start_ready), 64'd1);
    chk("vl0_ndone", 64'(n_done - d0), 64'd1);
    chk("vl0_no_valid", 64'(n_valid - v0), 64'd0);

    out_ready = 1'b0;
    d0 = n_done;
    start_desc(2'd0, 2'd0, 32'h2000, 32'h0, 7'd8);
    @(negedge CLK);
    a0 = out_addr; e0 = out_elem_idx;
    chk("hold_first_addr", 64'(a0), 64'h00002001_00002000);
    for (int i = 0; i < 3; i++) begin
      cyc(); @(negedge CLK);
      chk("hold_ready_addr", 64'(out_addr), 64'(a0));
      chk("hold_ready_elem", 64'(out_elem_idx), 64'(e0));
    end
    out_ready = 1'b1; stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc(); @(negedge CLK);
      chk("hold_stall_addr", 64'(out_addr), 64'(a0));
      chk("hold_stall_elem", 64'(out_elem_idx), 64'(e0));
    end
    stall = 1'b0;
    cyc(); @(negedge CLK);
    chk("beat2_elem", 64'(out_elem_idx), 64'd2);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    @(negedge CLK);
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_ready", 64'(start_ready), 64'd1);
    chk("flush_no_done", 64'(n_done - d0), 64'd0);

    for (int c = 0; c < 4000; c++) begin
      start_valid = 1'($urandom_range(0, 1));
      mode   = 2'($urandom_range(0, 2));
`ifdef RV32V_AGU_MISALIGN_CHECK_EN
      eew    = 2'd0;
`else
      eew    = 2'($urandom_range(0, 2));
`endif
      base   = $urandom;
      stride = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 32)) - 32'd16;
      vl     = ($urandom_range(0, 7) == 0) ? 7'($urandom) : 7'($urandom_range(0, 12));
      idx    = {$urandom, $urandom};
      mask   = 2'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      stall  = ($urandom_range(0, 7) == 0);
      flush  = ($urandom_range(0, 49) == 0);
      cyc();
    end
    start_valid = 1'b0; stall = 1'b0; flush = 1'b0; out_ready = 1'b1;
    wait_idle("random_drain");

`ifdef RV32V_AGU_MISALIGN_CHECK_EN
    chk_en = 1'b0;
    d0 = n_done; mask = 2'b11;
    start_desc(2'd0, 2'd2, 32'h1002, 32'h0, 7'd4);
    @(negedge CLK);
    chk("mis_err", 64'(misalign_err), 64'd1);
    chk("mis_lane", 64'(misalign_lane), 64'd3);
    cyc(); @(negedge CLK);
    chk("mis_idle", 64'(start_ready), 64'd1);
    chk("mis_no_valid", 64'(out_valid), 64'd0);
    chk("mis_no_done", 64'(n_done - d0), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
